multi_nb: RTL and testbench

- Parametrised sequential shift-add multiplier; next generation of the team's 8-bit radix-2 multiplier.
- Adds: WIDTH generalisation, full 2*WIDTH product, signed/unsigned mode per operation, busy indication, start ignored while busy, one-cycle done pulse.
- Sits beside the ULA as a multi-cycle arithmetic unit, driven by the same inicio/fim handshake.

---
 rtl/multi_pkg.sv | 15 +
 rtl/multi_abs.sv | 12 +
 rtl/multi_nb.sv | 112 +++++++++++
 tb/tb_multi_nb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pkg.sv
// Shared definitions for the multi-cycle arithmetic units (multiplier now, divider later).
package multi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        AJUSTE = 2'd2
    } state_t;

    // Width needed to hold a down-counter that starts at 'width'.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multi_abs.sv
// Conditional two's-complement negator: dout = neg ? -din : din.
module multi_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? -din : din;

endmodule

// File: rtl/multi_nb.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Optional early exit from CALC when the remaining multiplier is zero: define MULTI_EARLY_TERM_EN.
module multi_nb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inicio,
    input  logic               sinal,
    input  logic [WIDTH-1:0]   multiplicando,
    input  logic [WIDTH-1:0]   multiplicador,
    output logic [2*WIDTH-1:0] produto,
    output logic               ocupado,
    output logic               fim
);
    import multi_pkg::*;

    localparam int unsigned CW = cnt_w(WIDTH);

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] ma;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   mb_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic               last;
    logic               fim_nxt;

    multi_abs #(.W(WIDTH)) u_abs_a (
        .din  (multiplicando),
        .neg  (sinal & multiplicando[WIDTH-1]),
        .dout (abs_a)
    );

    multi_abs #(.W(WIDTH)) u_abs_b (
        .din  (multiplicador),
        .neg  (sinal & multiplicador[WIDTH-1]),
        .dout (abs_b)
    );

    multi_abs #(.W(2*WIDTH)) u_fix (
        .din  (acc),
        .neg  (neg),
        .dout (prod_fix)
    );

    assign mb_nxt = mb >> 1;

`ifdef MULTI_EARLY_TERM_EN
    assign last = (cnt == CW'(1)) || (mb_nxt == '0);
`else
    assign last = (cnt == CW'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (inicio) state_nxt = CALC;
            CALC:    if (last)   state_nxt = AJUSTE;
            AJUSTE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ocupado = (state != IDLE);
        fim_nxt = (state == AJUSTE);
    end

    // Datapath; produto only changes in AJUSTE so it stays valid until the next result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            produto <= '0;
            fim     <= 1'b0;
        end else begin
            fim <= fim_nxt;
            case (state)
                IDLE: begin
                    if (inicio) begin
                        ma  <= {{WIDTH{1'b0}}, abs_a};
                        mb  <= abs_b;
                        neg <= sinal & (multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1]);
                        acc <= '0;
                        cnt <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    if (mb[0]) acc <= acc + ma;
                    ma  <= ma << 1;
                    mb  <= mb_nxt;
                    cnt <= cnt - CW'(1);
                end
                AJUSTE: produto <= prod_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_nb.sv
// Directed bench for multi_nb at WIDTH=8 and WIDTH=16.
module tb_multi_nb;

`ifdef MULTI_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        i8, s8, o8, f8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        i16, s16, o16, f16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_nb #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .inicio(i8), .sinal(s8),
        .multiplicando(a8), .multiplicador(b8),
        .produto(p8), .ocupado(o8), .fim(f8)
    );

    multi_nb #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .inicio(i16), .sinal(s16),
        .multiplicando(a16), .multiplicador(b16),
        .produto(p16), .ocupado(o16), .fim(f16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edges after the accepting edge (edge 0) until the one that registers fim:
    // WIDTH CALC edges plus the AJUSTE edge, so fim is high when edge WIDTH+2 arrives.
    function automatic int exp_lat(input int w, input logic s, input logic [15:0] b);
        logic [15:0] m;
        int c;
        m = (s && b[w-1]) ? (16'd0 - b) : b;
        c = 1;
        for (int i = 0; i < w; i++) if (m[i]) c = i + 1;
        return EARLY ? c + 1 : w + 1;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
        i8 = 1'b1; s8 = s; a8 = a; b8 = b;
        @(posedge clk);
        @(negedge clk);
        i8 = 1'b0;
    endtask

    task automatic wait8(input string tag, input logic [15:0] exp, input int lat, input int k0);
        int k;
        logic busy;
        k = k0;
        busy = 1'b1;
        while (f8 !== 1'b1 && k < 40) begin
            busy &= o8;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check({tag, " lat"}, 64'(k), 64'(lat));
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " prod"}, 64'(p8), 64'(exp));
        check({tag, " idle"}, 64'(o8), 64'd0);
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
        start8(s, a, b);
        wait8(tag, exp, exp_lat(8, s, {8'h00, b}), 0);
        @(negedge clk);
        check({tag, " pulse"}, 64'(f8), 64'd0);
        check({tag, " hold"}, 64'(p8), 64'(exp));
    endtask

    task automatic run16(input string tag, input logic s, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp);
        int k;
        i16 = 1'b1; s16 = s; a16 = a; b16 = b;
        @(posedge clk);
        @(negedge clk);
        i16 = 1'b0;
        k = 0;
        while (f16 !== 1'b1 && k < 60) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check({tag, " lat"}, 64'(k), 64'(exp_lat(16, s, b)));
        check({tag, " prod"}, 64'(p16), 64'(exp));
        @(negedge clk);
        check({tag, " pulse"}, 64'(f16), 64'd0);
    endtask

    // Counts fim pulses over n cycles; none are expected.
    task automatic quiet8(input string tag, input int n);
        int seen;
        seen = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (f8 === 1'b1) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    logic        v8_s [7] = '{0, 1, 1, 0, 1, 1, 0};
    logic [7:0]  v8_a [7] = '{8'd13, 8'hFD, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [7:0]  v8_b [7] = '{8'd11, 8'h05, 8'h80, 8'hFF, 8'hFF, 8'h85, 8'h80};
    logic [15:0] v8_p [7] = '{16'h008F, 16'hFFF1, 16'h4000, 16'hFE01, 16'h0001, 16'h0000, 16'h4000};

    logic        v16_s [6] = '{0, 1, 1, 1, 0, 1};
    logic [15:0] v16_a [6] = '{16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h04D2, 16'h0100};
    logic [15:0] v16_b [6] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h162E, 16'hFF00};
    logic [31:0] v16_p [6] = '{32'hFFFE0001, 32'h40000000, 32'hFFFF8000,
                               32'hFFFF8001, 32'h006AE9BC, 32'hFFFF0000};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rs;
        logic [15:0] ra, rb;
        logic [31:0] rexp;
        int          seen;

        rst = 1'b0;
        i8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        i16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst prod8", 64'(p8), 64'd0);
        check("rst busy8", 64'(o8), 64'd0);
        check("rst fim8", 64'(f8), 64'd0);
        check("rst prod16", 64'(p16), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++)
            run8($sformatf("w8 v%0d", v), v8_s[v], v8_a[v], v8_b[v], v8_p[v]);

        run8("b1", 1'b0, 8'd37, 8'd1, 16'd37);
        run8("b0", 1'b1, 8'hF0, 8'd0, 16'd0);

        // Start request mid-operation must leave the running operands untouched.
        start8(1'b0, 8'd7, 8'd9);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        i8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
        @(posedge clk);
        @(negedge clk);
        i8 = 1'b0;
        wait8("busy", 16'd63, exp_lat(8, 1'b0, 16'd9), 4);
        quiet8("busy single", 12);

        // A request held during the fim cycle is accepted on the next edge.
        @(negedge clk);
        start8(1'b1, 8'hFD, 8'h05);
        wait8("b2b1", 16'hFFF1, exp_lat(8, 1'b1, 16'h0005), 0);
        start8(1'b0, 8'd5, 8'd6);
        check("b2b pulse", 64'(f8), 64'd0);
        wait8("b2b2", 16'd30, exp_lat(8, 1'b0, 16'd6), 0);
        @(negedge clk);
        check("b2b2 pulse", 64'(f8), 64'd0);

        start8(1'b0, 8'd13, 8'd11);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort prod", 64'(p8), 64'd0);
        check("abort fim", 64'(f8), 64'd0);
        check("abort busy", 64'(o8), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        quiet8("abort quiet", 15);
        @(negedge clk);
        run8("post rst", 1'b0, 8'd13, 8'd11, 16'h008F);

        for (int v = 0; v < 6; v++)
            run16($sformatf("w16 v%0d", v), v16_s[v], v16_a[v], v16_b[v], v16_p[v]);

        for (int v = 0; v < 6; v++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rs)
                rexp = 32'($signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb}));
            else
                rexp = {16'h0000, ra} * {16'h0000, rb};
            run16($sformatf("w16 r%0d", v), rs, ra, rb, rexp);
        end

        seen = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (f16 === 1'b1) seen++;
        end
        check("w16 quiet", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
